// File: rtl/ecp_dec_pkg.sv
// ecp_dec_pkg: class indices and decode FSM states shared by the ECP8 decode stage.
package ecp_dec_pkg;
  localparam int CLS_IMM    = 0;
  localparam int CLS_ALU    = 1;
  localparam int CLS_COPY   = 2;
  localparam int CLS_BRANCH = 3;
  typedef enum logic {S_OP, S_ARG} state_t;
endpackage

// File: rtl/dec_onehot.sv
// dec_onehot: extracts the class field from the top CLASS_W bits and expands it to one-hot.
module dec_onehot #(
  parameter int INSTR_W = 8,
  parameter int CLASS_W = 2
) (
  input  logic [INSTR_W-1:0]        instr,
  output logic [CLASS_W-1:0]        cls,
  output logic [(1<<CLASS_W)-1:0]   oh
);
  assign cls = CLASS_W'(instr >> (INSTR_W - CLASS_W));
  assign oh  = (1<<CLASS_W)'(1) << cls;
endmodule

// File: rtl/dec_stage.sv
// dec_stage: registered instruction decode with optional operand-beat gathering for one class.
module dec_stage import ecp_dec_pkg::*; #(
  parameter int INSTR_W   = 8,
  parameter int CLASS_W   = 2,
  parameter int EXT_EN    = 1,
  parameter int EXT_CLASS = CLS_IMM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INSTR_W-1:0]        in_instr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INSTR_W-1:0]        out_instr,
  output logic [INSTR_W-1:0]        out_operand,
  output logic                      out_has_operand,
  output logic [(1<<CLASS_W)-1:0]   out_class_oh
);
  localparam int NUM_CLASS = 1 << CLASS_W;
  localparam logic [NUM_CLASS-1:0] EXT_OH = NUM_CLASS'(1) << EXT_CLASS;
  state_t state, state_nx;
  logic [CLASS_W-1:0] cls;
  logic [NUM_CLASS-1:0] oh;
  logic [INSTR_W-1:0] hold;
  logic accept, is_ext, arg, grab, load;
  dec_onehot #(.INSTR_W(INSTR_W), .CLASS_W(CLASS_W)) u_onehot (
    .instr (in_instr),
    .cls   (cls),
    .oh    (oh)
  );
  assign is_ext = (EXT_EN != 0) && (cls == CLASS_W'(EXT_CLASS));
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_OP;
    else      state <= state_nx;
  always_comb
    state_nx = flush ? S_OP : !accept ? state : (state == S_OP && is_ext) ? S_ARG : S_OP;
  always_comb begin
    in_ready = !flush && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    arg      = state == S_ARG;
    grab     = accept && !arg && is_ext;
    load     = accept && (arg || !is_ext);
  end
  // Operand beat completes an instruction whose opcode waits in hold.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hold            <= '0;
      out_valid       <= 1'b0;
      out_instr       <= '0;
      out_operand     <= '0;
      out_has_operand <= 1'b0;
      out_class_oh    <= '0;
    end else begin
      if (flush)     hold <= '0;
      else if (grab) hold <= in_instr;
      if (flush)          out_valid <= 1'b0;
      else if (load)      out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (load) begin
        out_instr       <= arg ? hold : in_instr;
        out_operand     <= arg ? in_instr : '0;
        out_has_operand <= arg;
        out_class_oh    <= arg ? EXT_OH : oh;
      end
    end
endmodule

// File: tb/tb_dec_stage.sv
// tb_dec_stage: directed self-checking bench for dec_stage with hand-computed expectations.
module tb_dec_stage;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_instr = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_instr;
  logic [7:0] out_operand;
  logic       out_has_operand;
  logic [3:0] out_class_oh;
  int checks = 0;
  int errors = 0;

  dec_stage dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instr        (in_instr),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_operand     (out_operand),
    .out_has_operand (out_has_operand),
    .out_class_oh    (out_class_oh)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] b);
    in_valid = 1'b1;
    in_instr = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flush     = 1'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      in_instr  = 8'($urandom);
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %0b want 0", out_valid); end
      checks++; if (out_instr !== 8'h00 || out_operand !== 8'h00) begin errors++; $display("FAIL reset payload: got %h/%h want 00/00", out_instr, out_operand); end
      checks++; if (out_has_operand !== 1'b0 || out_class_oh !== 4'b0000) begin errors++; $display("FAIL reset class: got %0b/%b want 0/0000", out_has_operand, out_class_oh); end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    beat(8'h45);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single valid: got %0b want 1", out_valid); end
    checks++; if (out_instr !== 8'h45 || out_operand !== 8'h00) begin errors++; $display("FAIL single payload: got %h/%h want 45/00", out_instr, out_operand); end
    checks++; if (out_class_oh !== 4'b0010 || out_has_operand !== 1'b0) begin errors++; $display("FAIL single class: got %b/%0b want 0010/0", out_class_oh, out_has_operand); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_two_beat();
    out_ready = 1'b1;
    beat(8'h03);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL two_beat first: got valid %0b want 0", out_valid); end
    beat(8'h7F);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL two_beat valid: got %0b want 1", out_valid); end
    checks++; if (out_instr !== 8'h03 || out_operand !== 8'h7F) begin errors++; $display("FAIL two_beat payload: got %h/%h want 03/7f", out_instr, out_operand); end
    checks++; if (out_has_operand !== 1'b1 || out_class_oh !== 4'b0001) begin errors++; $display("FAIL two_beat class: got %0b/%b want 1/0001", out_has_operand, out_class_oh); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    beat(8'h81);
    checks++; if (out_valid !== 1'b1 || out_instr !== 8'h81) begin errors++; $display("FAIL bp load: got %0b/%h want 1/81", out_valid, out_instr); end
    in_valid = 1'b1; in_instr = 8'hC2;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp in_ready stalled: got %0b want 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_instr !== 8'h81 || out_class_oh !== 4'b0100) begin errors++; $display("FAIL bp hold: got %0b/%h/%b want 1/81/0100", out_valid, out_instr, out_class_oh); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp in_ready released: got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 8'hC2 || out_class_oh !== 4'b1000) begin errors++; $display("FAIL bp swap: got %0b/%h/%b want 1/c2/1000", out_valid, out_instr, out_class_oh); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    beat(8'h03);
    flush = 1'b1; in_valid = 1'b1; in_instr = 8'h55;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush in_ready: got %0b want 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush valid: got %0b want 0", out_valid); end
    beat(8'h80);
    checks++; if (out_valid !== 1'b1 || out_instr !== 8'h80 || out_class_oh !== 4'b0100) begin errors++; $display("FAIL flush next: got %0b/%h/%b want 1/80/0100", out_valid, out_instr, out_class_oh); end
    checks++; if (out_has_operand !== 1'b0 || out_operand !== 8'h00) begin errors++; $display("FAIL flush operand: got %0b/%h want 0/00", out_has_operand, out_operand); end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    beat(8'h45);
    beat(8'h03);
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_instr !== 8'h00 || out_class_oh !== 4'b0000) begin errors++; $display("FAIL async clear: got %0b/%h/%b want 0/00/0000", out_valid, out_instr, out_class_oh); end
    #1 rst = 1'b1;
    beat(8'h41);
    checks++; if (out_valid !== 1'b1 || out_instr !== 8'h41 || out_class_oh !== 4'b0010) begin errors++; $display("FAIL async next: got %0b/%h/%b want 1/41/0010", out_valid, out_instr, out_class_oh); end
    checks++; if (out_has_operand !== 1'b0 || out_operand !== 8'h00) begin errors++; $display("FAIL async operand: got %0b/%h want 0/00", out_has_operand, out_operand); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_beat();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
